dcache_nway: RTL and testbench

Parametrised write-back, write-allocate, N-way set-associative data cache between the datapath memory stage and the memory/bus controller. It generalises the two-way, two-word-block data cache to configurable way count, set count and block size. Replacement is true LRU via per-way age counters, and line transfers are multi-word bursts. On halt it flushes every dirty frame, optionally writes a hit statistic, then asserts `flushed`.

---
 rtl/dcache_nway.sv | 252 +++++++++++++++++++++++++
 tb/tb_dcache_nway.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU age counters and burst line transfers.
// Optional hit/miss statistic write on halt is enabled by defining DCACHE_STATS_EN.
module dcache_nway #(
    parameter int WAYS     = 2,
    parameter int SETS     = 8,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int WAYW = $clog2(WAYS);
    localparam int IDXW = $clog2(SETS);
    localparam int BOW  = $clog2(BLKWORDS);
    localparam int TAGW = 30 - BOW - IDXW;
    localparam int NFR  = SETS * WAYS;
    localparam int FW   = $clog2(NFR) + 1;
    localparam logic [BOW-1:0] K_LAST = BOW'(BLKWORDS - 1);

`ifdef DCACHE_STATS_EN
    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_CHK, FLUSH_WB, COUNT, HALT} state_t;
`else
    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_CHK, FLUSH_WB, HALT} state_t;
`endif

    state_t            r_state;
    logic              r_valid [SETS][WAYS];
    logic              r_dirty [SETS][WAYS];
    logic [TAGW-1:0]   r_tag   [SETS][WAYS];
    logic [WAYW-1:0]   r_age   [SETS][WAYS];
    logic [31:0]       r_data  [SETS][WAYS][BLKWORDS];
    logic [TAGW-1:0]   r_req_tag;
    logic [IDXW-1:0]   r_req_idx;
    logic [WAYW-1:0]   r_victim;
    logic [BOW-1:0]    r_k;
    logic [FW-1:0]     r_f;
`ifdef DCACHE_STATS_EN
    logic [31:0]       r_hit_count;
    logic [31:0]       r_miss_count;
`endif

    logic [TAGW-1:0]   w_tag;
    logic [IDXW-1:0]   w_idx;
    logic [BOW-1:0]    w_boff;
    logic              w_req;
    logic [WAYS-1:0]   w_match;
    logic              w_hit;
    logic [WAYW-1:0]   w_hitway;
    logic [WAYW-1:0]   w_victim;
    logic              w_flushing;
    logic [IDXW-1:0]   w_set;
    logic [WAYW-1:0]   w_way;
    logic              w_touch_en;
    logic [IDXW-1:0]   w_touch_set;
    logic [WAYW-1:0]   w_touch_way;
    logic              w_unused;

    assign w_tag    = dmemaddr[31 -: TAGW];
    assign w_idx    = dmemaddr[2 + BOW +: IDXW];
    assign w_boff   = dmemaddr[2 +: BOW];
    assign w_req    = dmemREN | dmemWEN;
    assign w_unused = &{1'b0, dmemaddr[1:0]};

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
        assign w_match[gi] = r_valid[w_idx][gi] && (r_tag[w_idx][gi] == w_tag);
    end
    assign w_hit = |w_match;

    always_comb begin
        w_hitway = '0;
        for (int i = 0; i < WAYS; i++)
            if (w_match[i]) w_hitway = WAYW'(i);
    end

    // Oldest way first, then overridden by the lowest-index invalid way if any exists.
    always_comb begin
        w_victim = '0;
        for (int i = 0; i < WAYS; i++)
            if (r_age[w_idx][i] == WAYW'(WAYS - 1)) w_victim = WAYW'(i);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!r_valid[w_idx][i]) w_victim = WAYW'(i);
    end

    assign dhit     = (r_state == IDLE) && !halt && w_req && w_hit;
    assign dmemload = (dhit && dmemREN) ? r_data[w_idx][w_hitway][w_boff] : 32'h0;
    assign flushed  = (r_state == HALT);

    assign w_flushing = (r_state == FLUSH_CHK) || (r_state == FLUSH_WB);
    assign w_set      = w_flushing ? r_f[IDXW-1:0]     : r_req_idx;
    assign w_way      = w_flushing ? r_f[IDXW +: WAYW] : r_victim;

    always_comb begin
        w_touch_en  = 1'b0;
        w_touch_set = w_idx;
        w_touch_way = w_hitway;
        if (dhit) begin
            w_touch_en = 1'b1;
        end else if (r_state == FILL && !dwait && r_k == K_LAST) begin
            w_touch_en  = 1'b1;
            w_touch_set = r_req_idx;
            w_touch_way = r_victim;
        end
    end

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = 32'h0;
        dstore = 32'h0;
        case (r_state)
            WB, FLUSH_WB: begin
                dWEN   = 1'b1;
                daddr  = {r_tag[w_set][w_way], w_set, r_k, 2'b00};
                dstore = r_data[w_set][w_way][r_k];
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {r_req_tag, r_req_idx, r_k, 2'b00};
            end
`ifdef DCACHE_STATS_EN
            COUNT: begin
                dWEN   = 1'b1;
                daddr  = 32'h0000_3100;
                dstore = r_hit_count - r_miss_count;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (dhit && dmemWEN)
            r_data[w_idx][w_hitway][w_boff] <= dmemstore;
        if (r_state == FILL && !dwait)
            r_data[r_req_idx][r_victim][r_k] <= dload;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_req_tag <= '0;
            r_req_idx <= '0;
            r_victim  <= '0;
            r_k       <= '0;
            r_f       <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_age[s][w]   <= WAYW'(w);
                end
`ifdef DCACHE_STATS_EN
            r_hit_count  <= '0;
            r_miss_count <= '0;
`endif
        end else begin
            // Touched way becomes youngest; only ways younger than it age, keeping ages a permutation.
            if (w_touch_en)
                for (int i = 0; i < WAYS; i++)
                    if (WAYW'(i) == w_touch_way)
                        r_age[w_touch_set][i] <= '0;
                    else if (r_age[w_touch_set][i] < r_age[w_touch_set][w_touch_way])
                        r_age[w_touch_set][i] <= r_age[w_touch_set][i] + WAYW'(1);
`ifdef DCACHE_STATS_EN
            if (dhit) r_hit_count <= r_hit_count + 32'd1;
`endif
            case (r_state)
                IDLE: begin
                    if (halt) begin
                        r_state <= FLUSH_CHK;
                        r_f     <= '0;
                    end else if (w_req) begin
                        if (w_hit) begin
                            if (dmemWEN) r_dirty[w_idx][w_hitway] <= 1'b1;
                        end else begin
                            r_req_tag <= w_tag;
                            r_req_idx <= w_idx;
                            r_victim  <= w_victim;
                            r_k       <= '0;
                            r_state   <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? WB : FILL;
                        end
                    end
                end
                WB: begin
                    if (!dwait) begin
                        r_k <= r_k + BOW'(1);
                        if (r_k == K_LAST) r_state <= FILL;
                    end
                end
                FILL: begin
                    if (!dwait) begin
                        r_k <= r_k + BOW'(1);
                        if (r_k == K_LAST) begin
                            r_valid[r_req_idx][r_victim] <= 1'b1;
                            r_dirty[r_req_idx][r_victim] <= 1'b0;
                            r_tag[r_req_idx][r_victim]   <= r_req_tag;
`ifdef DCACHE_STATS_EN
                            r_miss_count <= r_miss_count + 32'd1;
`endif
                            r_state <= IDLE;
                        end
                    end
                end
                FLUSH_CHK: begin
                    if (r_f == FW'(NFR)) begin
`ifdef DCACHE_STATS_EN
                        r_state <= COUNT;
`else
                        r_state <= HALT;
`endif
                    end else if (r_dirty[w_set][w_way]) begin
                        r_k     <= '0;
                        r_state <= FLUSH_WB;
                    end else begin
                        r_f <= r_f + FW'(1);
                    end
                end
                FLUSH_WB: begin
                    if (!dwait) begin
                        r_k <= r_k + BOW'(1);
                        if (r_k == K_LAST) begin
                            r_dirty[w_set][w_way] <= 1'b0;
                            r_f     <= r_f + FW'(1);
                            r_state <= FLUSH_CHK;
                        end
                    end
                end
`ifdef DCACHE_STATS_EN
                COUNT: begin
                    if (!dwait) r_state <= HALT;
                end
`endif
                HALT: ;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Randomised bench for dcache_nway against a timestamp-LRU cache model and a flat golden memory.
`timescale 1ns/1ps
module tb_dcache_nway;
    localparam int WAYS = 2, SETS = 8, BLKWORDS = 2;
    localparam int BOW = $clog2(BLKWORDS), IDXW = $clog2(SETS);

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b0;
    logic [31:0] dmemaddr = 32'h0, dmemstore = 32'h0, dload = 32'h0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_nway #(.WAYS(WAYS), .SETS(SETS), .BLKWORDS(BLKWORDS)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } memop_t;

    int n_checks = 0, n_errors = 0;
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] gold [logic [31:0]];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int unsigned m_used  [SETS][WAYS];
    int unsigned now_t = 0;
    memop_t      expq[$];
    int          stall_pct = 0, n_stall = 0, n_req = 0, n_miss = 0;
    bit          held = 0;
    logic [31:0] held_addr = 32'h0, last_addr = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bm_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a ^ 32'hAAAA_0000;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return a ^ 32'hAAAA_0000;
    endfunction

    function automatic logic [31:0] blk_addr(input int unsigned t, input int s, input int k);
        return 32'((t << (2 + BOW + IDXW)) | (s << (2 + BOW)) | (k << 2));
    endfunction

    task automatic reset_model();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; m_used[s][w] = 0;
            end
        now_t = 0; n_req = 0; n_miss = 0; held = 0;
        expq.delete();
        gold = bmem;
    endtask

    // Acts as main memory for one cycle; called at the falling edge.
    task automatic serve_mem(input bit chk);
        memop_t e;
        dwait = 1'b0;
        dload = 32'h0;
        if (dREN || dWEN) begin
            if (held) check("stall_addr_hold", daddr, held_addr);
            dwait = ($urandom_range(0, 99) < stall_pct);
            if (dREN) dload = bm_rd(daddr);
            if (dwait) n_stall++;
            else begin
                if (dWEN) bmem[daddr] = dstore;
                if (chk) begin
                    if (expq.size() == 0) check("mem_extra_op", {30'b0, dREN, dWEN}, 32'h0);
                    else begin
                        e = expq.pop_front();
                        check("mem_we", 32'(dWEN), 32'(e.we));
                        check("mem_addr", daddr, e.addr);
                        if (e.we) check("mem_data", dstore, e.data);
                    end
                end
            end
            held = dwait;
            held_addr = daddr;
        end else held = 0;
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int s, hw, v, cyc, nmem;
        int unsigned t;
        bit ehit, got_hit;
        memop_t e;
        s = int'((addr >> (2 + BOW)) % SETS);
        t = addr >> (2 + BOW + IDXW);
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        ehit = (hw >= 0);
        v = hw;
        expq.delete();
        if (!ehit) begin
            v = -1;
            for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < WAYS; w++) if (m_used[s][w] < m_used[s][v]) v = w;
            end
            if (m_valid[s][v] && m_dirty[s][v])
                for (int k = 0; k < BLKWORDS; k++) begin
                    e.we = 1; e.addr = blk_addr(m_tag[s][v], s, k); e.data = gold_rd(e.addr);
                    expq.push_back(e);
                end
            for (int k = 0; k < BLKWORDS; k++) begin
                e.we = 0; e.addr = blk_addr(t, s, k); e.data = 32'h0;
                expq.push_back(e);
            end
        end
        nmem = expq.size();
        n_stall = 0;
        dmemREN = !we; dmemWEN = we; dmemaddr = addr; dmemstore = wdata;
        cyc = 0; got_hit = 0;
        while (cyc < 200) begin
            @(negedge CLK);
            serve_mem(1);
            if (dhit) begin got_hit = 1; break; end
            @(posedge CLK); #1;
            cyc++;
        end
        check("req_done", 32'(got_hit), 32'd1);
        check("hit_first_cycle", 32'(cyc == 0), 32'(ehit));
        check("miss_latency", 32'(cyc - n_stall), ehit ? 32'd0 : 32'(1 + nmem));
        check("mem_ops_left", 32'(expq.size()), 32'd0);
        if (!we) check("rd_data", dmemload, gold_rd(addr));
        if (!ehit) begin
            m_valid[s][v] = 1; m_dirty[s][v] = 0; m_tag[s][v] = t; n_miss++;
        end
        now_t++;
        m_used[s][v] = now_t;
        if (we) begin m_dirty[s][v] = 1; gold[addr] = wdata; end
        n_req++;
        last_addr = addr;
        $display("req %0d %s addr=%08h %s way=%0d stalls=%0d", n_req, we ? "WR" : "RD", addr,
                 ehit ? "hit" : "miss", v, n_stall);
        @(posedge CLK); #1;
        dmemREN = 0; dmemWEN = 0;
    endtask

    task automatic do_flush();
        memop_t e;
        bit done;
        expq.delete();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    for (int k = 0; k < BLKWORDS; k++) begin
                        e.we = 1; e.addr = blk_addr(m_tag[s][w], s, k); e.data = gold_rd(e.addr);
                        expq.push_back(e);
                    end
                    m_dirty[s][w] = 0;
                end
`ifdef DCACHE_STATS_EN
        e.we = 1; e.addr = 32'h3100; e.data = 32'(n_req - n_miss);
        expq.push_back(e);
`endif
        $display("flush: expecting %0d memory writes", expq.size());
        halt = 1; done = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge CLK);
            serve_mem(1);
            if (flushed) begin done = 1; break; end
            @(posedge CLK); #1;
        end
        check("flush_done", 32'(done), 32'd1);
        check("flush_ops_left", 32'(expq.size()), 32'd0);
        @(posedge CLK); #1;
        halt = 0;
        dmemREN = 1; dmemaddr = last_addr;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("halt_no_hit", 32'(dhit), 32'd0);
            check("flushed_sticky", 32'(flushed), 32'd1);
            check("halt_no_mem", {30'b0, dREN, dWEN}, 32'h0);
            @(posedge CLK); #1;
        end
        dmemREN = 0;
    endtask

    initial begin
        bit seen;
        logic [31:0] a;
        reset_model();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_flags", {28'b0, dhit, flushed, dREN, dWEN}, 32'h0);
        check("rst_daddr", daddr, 32'h0);
        check("rst_dstore", dstore, 32'h0);
        check("rst_dmemload", dmemload, 32'h0);
        nRST = 1;
        @(posedge CLK); #1;

        // Directed: cold miss, write hit, dirty LRU eviction.
        stall_pct = 0;
        do_req(0, 32'h40, 32'h0);
        do_req(1, 32'h44, 32'h1234);
        do_req(0, 32'h44, 32'h0);
        do_req(1, 32'h40, 32'hCAFE_0040);
        do_req(0, 32'h80, 32'h0);
        do_req(0, 32'hC0, 32'h0);
        do_req(0, 32'h80, 32'h0);

        stall_pct = 30;
        for (int i = 0; i < 150; i++) begin
            a = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS - 1) << 3) |
                    ($urandom_range(0, 1) << 2));
            do_req(1'($urandom_range(0, 1)), a, $urandom);
        end
        do_flush();

        // Reset in the middle of a dirty writeback burst.
        nRST = 0;
        @(posedge CLK); #1;
        check("rst2_flushed", 32'(flushed), 32'd0);
        nRST = 1;
        reset_model();
        @(posedge CLK); #1;
        stall_pct = 0;
        do_req(1, 32'h40, 32'h5555_AAAA);
        do_req(0, 32'h80, 32'h0);
        dmemREN = 1; dmemaddr = 32'hC0; seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (dWEN && daddr == 32'h44) begin seen = 1; break; end
            serve_mem(0);
            @(posedge CLK); #1;
        end
        check("rst_wb1_seen", 32'(seen), 32'd1);
        #2 nRST = 0;
        #1;
        check("rst_mid_flags", {28'b0, dhit, flushed, dREN, dWEN}, 32'h0);
        check("rst_mid_daddr", daddr, 32'h0);
        check("rst_mid_dstore", dstore, 32'h0);
        dmemREN = 0;
        dwait = 0;
        @(posedge CLK); #1;
        nRST = 1;
        reset_model();
        @(posedge CLK); #1;
        do_req(0, 32'h80, 32'h0);
        do_req(0, 32'h44, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
